// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned ADDR_W  = 7;
  localparam int unsigned INSTR_W = 9;

  // Reserved encoding that stops the program; it has no other effect.
  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fetch_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear and a count enable.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Clear has priority; counting stops once every bit is set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns the PC, addresses the instruction ROM and holds the
// fetched word for execute; handles start/done, branches, stalls and halt.
module instr_fetch_ctrl #(
  parameter int unsigned                 ADDR_W     = fetch_pkg::ADDR_W,
  parameter int unsigned                 INSTR_W    = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]           START_ADDR = '0,
  parameter logic [INSTR_W-1:0]          HALT_INSTR = fetch_pkg::HALT_INSTR,
  parameter int unsigned                 CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   cycle_cnt
);

  import fetch_pkg::*;

  fetch_state_t state;
  logic         run_en;

  assign rom_addr = pc;
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign run_en   = (state == RUN);

  // Control FSM with PC, fetch register and sticky wrap flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      instr       <= '0;
      instr_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_ADDR;
            instr_valid <= 1'b0;
            err         <= 1'b0;
          end
        end
        RUN: begin
          if (start) begin
            state       <= RUN;
            pc          <= START_ADDR;
            instr_valid <= 1'b0;
            err         <= 1'b0;
          end else if (instr_valid && (instr == HALT_INSTR)) begin
            state       <= DONE;
            instr_valid <= 1'b0;
          end else if (stall) begin
            // Everything holds; a pending branch is re-presented after the stall.
          end else if (branch_taken && instr_valid) begin
            pc          <= branch_target;
            instr_valid <= 1'b0;
          end else begin
            instr       <= rom_instr;
            instr_valid <= 1'b1;
            pc          <= pc + 1'b1;
            if (pc == '1) begin
              err <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

  // Start always clears; only RUN cycles are counted.
  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start),
    .en    (run_en),
    .cnt   (cycle_cnt)
  );

endmodule
